cp0_regs: RTL and testbench
===========================

Name: cp0_regs

Overview:
- Coprocessor-0 register file; the consumer end of the exception unit's CP0 write interface.
- Latches exception state (EPC, Cause.ExcCode/BD, BadVAddr, EntryHi.ASID, Status.EXL) and serves MFC0/MTC0 from the pipeline.
- Feeds control back to the exception unit and the MMU: interrupt enable, pending interrupts, EBase, EPC, IV, BEV, EXL, current ASID.
- Also owns the Count/Compare timer.

Parameters:
- PRID_VALUE, 32'h0001_8000, read-only PRId contents.
- EBASE_RESET, 32'h8000_0000, EBase reset value; only bits [29:12] are writable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  8  {reg[4:0], sel[2:0]} for MFC0.
- rd_data  out  32  combinational read of current register value.
- we  in  1  MTC0 write enable.
- wr_addr  in  8  {reg, sel} for MTC0.
- wr_data  in  32  MTC0 data.
- hw_int  in  6  external hardware interrupt lines.
- cp0_wr_exp  in  1  exception being taken this cycle.
- cp0_clean_exl  in  1  ERET this cycle.
- exp_epc  in  32  return address.
- exp_in_delayslot  in  1  faulting instruction was in a delay slot.
- exp_code  in  5  ExcCode.
- exp_bad_vaddr  in  32  faulting address.
- cp0_badv_we  in  1  write BadVAddr.
- exp_asid  in  8  faulting ASID.
- cp0_exp_asid_we  in  1  write EntryHi.ASID.
- allow_int  out  1  Status.IE & ~Status.EXL.
- int_pending  out  8  Cause.IP & Status.IM.
- ebase_out  out  20  EBase[31:12].
- epc_out  out  32  EPC.
- special_int_vec  out  1  Cause.IV.
- boot_exp_vec  out  1  Status.BEV.
- exl_out  out  1  Status.EXL.
- asid_out  out  8  EntryHi[7:0].

Behaviour:
- Register map:
  - BadVAddr (8,0): read-only to MTC0.
  - Count (9,0).
  - EntryHi (10,0): bits [31:13] and [7:0] writable; rest read 0.
  - Compare (11,0).
  - Status (12,0): CU0 bit28, BEV bit22, IM [15:8], UM bit4, EXL bit1, IE bit0 writable; others read 0.
  - Cause (13,0): BD 31, TI 30, IV 23 writable, IP[15:10] hardware, IP[9:8] writable, ExcCode [6:2].
  - EPC (14,0).
  - PRId (15,0).
  - EBase (15,1).
  - Unmapped addresses read 0; writes to them are ignored.
- Reset (async): Status = 32'h0040_0000 (BEV=1, EXL=0, IE=0). Cause, EPC, BadVAddr, EntryHi, Count and Compare = 0. EBase = EBASE_RESET. All outputs derive from these, so allow_int=0 and boot_exp_vec=1 at reset.
- MTC0 takes effect at the next edge. An MFC0 in the same cycle returns the old value (no bypass).
- Exception (cp0_wr_exp=1), applied at the edge:
  - ExcCode <= exp_code.
  - If EXL was 0: EPC <= exp_epc and BD <= exp_in_delayslot. If EXL was 1: EPC and BD are unchanged.
  - EXL <= 1.
  - If cp0_badv_we: BadVAddr <= exp_bad_vaddr.
  - If cp0_exp_asid_we: EntryHi[7:0] <= exp_asid.
- Simultaneous events:
  - An exception overrides an MTC0 in the same cycle: the whole MTC0 is dropped.
  - cp0_clean_exl with cp0_wr_exp cannot occur (the upstream unit prioritises them). If both arrive, cp0_wr_exp wins.
- ERET (cp0_clean_exl=1, cp0_wr_exp=0): EXL <= 0. A concurrent MTC0 to Status still applies to all bits except EXL; the EXL clear wins.
- IP[15:10] are registered each cycle from {hw_int[5] | TI, hw_int[4:0]}, giving 1 cycle of latency from hw_int to int_pending.
- Timer:
  - Count increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - An MTC0 to Count loads wr_data instead of incrementing that cycle.
  - TI is set at the edge where the current Count equals Compare.
  - An MTC0 to Compare clears TI and suppresses setting TI that cycle.
  - TI stays set until Compare is written.

Optional Feature:
- CP0_TIMER_EN
  - Defined: Count/Compare/TI behave as above.
  - Undefined: Count and Compare read 0, ignore writes, TI is constantly 0, and IP7 = hw_int[5] only.

Decomposition:
- Package cp0_defs holds:
  - register/select address constants;
  - Status/Cause bit positions;
  - ExcCode constants (Int 0, Mod 1, TLBL 2, TLBS 3, AdEL 4, AdES 5, Sys 8, RI 10, CpU 11, Ov 12);
  - the Status reset constant.
- Sub-module cp0_timer holds Count, Compare and TI, plus the write/load/clear logic. It is instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset check: assert rst mid-run -> Status reads 32'h0040_0000, EBase reads 32'h8000_0000, boot_exp_vec=1, allow_int=0, Count=0 immediately (no clock required).
- Exception with EXL=0, then nested exception: exp_epc=32'hBFC0_0104, delayslot=1, code 5'h02, badv_we=1, vaddr=32'h0040_1000 -> EPC=32'hBFC0_0104, Cause.BD=1, ExcCode=2, BadVAddr=32'h0040_1000, EXL=1. A second exception with exp_epc=32'h8000_0010 -> EPC unchanged, ExcCode updated.
- ERET racing an MTC0: ERET plus MTC0 Status=32'h0000_FF03 in the same cycle -> Status=32'h0000_FF01, EXL=0, allow_int=1.
- Exception racing an MTC0: MTC0 EPC=32'h1234_5678 together with cp0_wr_exp -> EPC takes exp_epc, write dropped.
- Timer (CP0_TIMER_EN): write Compare=20, Count=10 -> TI=1 and int_pending[7]=1 (with IM7=1) at the 11th edge after the Count write. Write Compare -> TI=0. Count=32'hFFFF_FFFF -> 0 next cycle.
- Software/hardware interrupts: MTC0 Cause with IP[9:8]=2'b01 and IM=8'h01 -> int_pending=8'h01. hw_int=6'b000100 with IM4=1 -> int_pending[4] rises exactly 1 cycle later.

Source files
------------

// File: rtl/cp0_regs_pkg.sv
// Shared CP0 definitions: register addresses, Status/Cause bit positions,
// write masks, exception codes and reset constants.
package cp0_defs;

  // {reg[4:0], sel[2:0]} addresses
  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_ENTRYHI  = 8'h50;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;
  localparam logic [7:0] ADDR_PRID     = 8'h78;
  localparam logic [7:0] ADDR_EBASE    = 8'h79;

  localparam int ST_CU0   = 28;
  localparam int ST_BEV   = 22;
  localparam int ST_IM_LO = 8;
  localparam int ST_UM    = 4;
  localparam int ST_EXL   = 1;
  localparam int ST_IE    = 0;

  localparam int CA_BD     = 31;
  localparam int CA_TI     = 30;
  localparam int CA_IV     = 23;
  localparam int CA_IP_LO  = 8;
  localparam int CA_EXC_LO = 2;

  localparam logic [31:0] STATUS_RESET  = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK  = 32'h1040_FF13;
  localparam logic [31:0] ENTRYHI_WMASK = 32'hFFFF_E0FF;
  localparam logic [31:0] EBASE_WMASK   = 32'h3FFF_F000;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12
  } exc_code_e;

  function automatic logic [31:0] merge_masked(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with the TI latch; only instantiated when CP0_TIMER_EN is defined.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti,
  output logic        o_ti_next
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_ti_next;

  // A Compare write both clears TI and masks a match in the same cycle
  assign w_ti_next = i_compare_we ? 1'b0 : (r_ti | (r_count == r_compare));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_count <= i_count_we ? i_wr_data : r_count + 32'd1;
      if (i_compare_we)
        r_compare <= i_wr_data;
      r_ti <= w_ti_next;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;
  assign o_ti_next = w_ti_next;

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: exception state capture, MFC0/MTC0 access and control outputs.
// Define CP0_TIMER_EN to include the Count/Compare timer.
module cp0_regs
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VALUE  = 32'h0001_8000,
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        we,
  input  logic [7:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [5:0]  hw_int,
  input  logic        cp0_wr_exp,
  input  logic        cp0_clean_exl,
  input  logic [31:0] exp_epc,
  input  logic        exp_in_delayslot,
  input  logic [4:0]  exp_code,
  input  logic [31:0] exp_bad_vaddr,
  input  logic        cp0_badv_we,
  input  logic [7:0]  exp_asid,
  input  logic        cp0_exp_asid_we,
  output logic        allow_int,
  output logic [7:0]  int_pending,
  output logic [19:0] ebase_out,
  output logic [31:0] epc_out,
  output logic        special_int_vec,
  output logic        boot_exp_vec,
  output logic        exl_out,
  output logic [7:0]  asid_out
);

  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_entryhi;
  logic [31:0] r_ebase;
  logic        r_cause_bd;
  logic        r_cause_iv;
  logic [1:0]  r_cause_ip_sw;
  logic [5:0]  r_cause_ip_hw;
  logic [4:0]  r_cause_exc;

  logic        w_mtc0;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic        w_ti_next;
  logic [31:0] w_cause;
  logic [7:0]  w_ip;

  // An exception in the same cycle drops the whole MTC0
  assign w_mtc0 = we & ~cp0_wr_exp;

`ifdef CP0_TIMER_EN
  logic w_wr_count;
  logic w_wr_compare;

  assign w_wr_count   = w_mtc0 & (wr_addr == ADDR_COUNT);
  assign w_wr_compare = w_mtc0 & (wr_addr == ADDR_COMPARE);

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_count_we   (w_wr_count),
    .i_compare_we (w_wr_compare),
    .i_wr_data    (wr_data),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti),
    .o_ti_next    (w_ti_next)
  );
`else
  assign w_count   = '0;
  assign w_compare = '0;
  assign w_ti      = 1'b0;
  assign w_ti_next = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status      <= STATUS_RESET;
      r_epc         <= '0;
      r_badvaddr    <= '0;
      r_entryhi     <= '0;
      r_ebase       <= EBASE_RESET;
      r_cause_bd    <= 1'b0;
      r_cause_iv    <= 1'b0;
      r_cause_ip_sw <= '0;
      r_cause_ip_hw <= '0;
      r_cause_exc   <= '0;
    end else begin
      // Timer source uses TI's next state so IP7 rises on the same edge as TI
      r_cause_ip_hw <= {hw_int[5] | w_ti_next, hw_int[4:0]};
      if (cp0_wr_exp) begin
        r_cause_exc <= exp_code;
        if (!r_status[ST_EXL]) begin
          r_epc      <= exp_epc;
          r_cause_bd <= exp_in_delayslot;
        end
        r_status[ST_EXL] <= 1'b1;
        if (cp0_badv_we)
          r_badvaddr <= exp_bad_vaddr;
        if (cp0_exp_asid_we)
          r_entryhi[7:0] <= exp_asid;
      end else begin
        if (w_mtc0 && wr_addr == ADDR_STATUS)
          r_status <= merge_masked(r_status, wr_data, STATUS_WMASK);
        if (cp0_clean_exl)
          r_status[ST_EXL] <= 1'b0;
        if (w_mtc0 && wr_addr == ADDR_CAUSE) begin
          r_cause_iv    <= wr_data[CA_IV];
          r_cause_ip_sw <= wr_data[CA_IP_LO +: 2];
        end
        if (w_mtc0 && wr_addr == ADDR_EPC)
          r_epc <= wr_data;
        if (w_mtc0 && wr_addr == ADDR_ENTRYHI)
          r_entryhi <= merge_masked(r_entryhi, wr_data, ENTRYHI_WMASK);
        if (w_mtc0 && wr_addr == ADDR_EBASE)
          r_ebase <= merge_masked(r_ebase, wr_data, EBASE_WMASK);
      end
    end
  end

  assign w_ip    = {r_cause_ip_hw, r_cause_ip_sw};
  assign w_cause = {r_cause_bd, w_ti, 6'b0, r_cause_iv, 7'b0, w_ip, 1'b0, r_cause_exc, 2'b0};

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_BADVADDR: rd_data = r_badvaddr;
      ADDR_COUNT:    rd_data = w_count;
      ADDR_ENTRYHI:  rd_data = r_entryhi;
      ADDR_COMPARE:  rd_data = w_compare;
      ADDR_STATUS:   rd_data = r_status;
      ADDR_CAUSE:    rd_data = w_cause;
      ADDR_EPC:      rd_data = r_epc;
      ADDR_PRID:     rd_data = PRID_VALUE;
      ADDR_EBASE:    rd_data = r_ebase;
      default:       rd_data = '0;
    endcase
  end

  assign allow_int       = r_status[ST_IE] & ~r_status[ST_EXL];
  assign int_pending     = w_ip & r_status[ST_IM_LO +: 8];
  assign ebase_out       = r_ebase[31:12];
  assign epc_out         = r_epc;
  assign special_int_vec = r_cause_iv;
  assign boot_exp_vec    = r_status[ST_BEV];
  assign exl_out         = r_status[ST_EXL];
  assign asid_out        = r_entryhi[7:0];

endmodule

// File: tb/tb_cp0_regs.sv
// Directed testbench for cp0_regs; timer checks depend on CP0_TIMER_EN.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        we;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  hw_int;
  logic        cp0_wr_exp;
  logic        cp0_clean_exl;
  logic [31:0] exp_epc;
  logic        exp_in_delayslot;
  logic [4:0]  exp_code;
  logic [31:0] exp_bad_vaddr;
  logic        cp0_badv_we;
  logic [7:0]  exp_asid;
  logic        cp0_exp_asid_we;
  logic        allow_int;
  logic [7:0]  int_pending;
  logic [19:0] ebase_out;
  logic [31:0] epc_out;
  logic        special_int_vec;
  logic        boot_exp_vec;
  logic        exl_out;
  logic [7:0]  asid_out;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] d;

  localparam logic [7:0] A_BADV = 8'h40, A_COUNT = 8'h48, A_ENTRYHI = 8'h50,
                         A_COMPARE = 8'h58, A_STATUS = 8'h60, A_CAUSE = 8'h68,
                         A_EPC = 8'h70, A_PRID = 8'h78, A_EBASE = 8'h79;

  always #5 clk = ~clk;

  cp0_regs dut (
    .clk              (clk),
    .rst              (rst),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .we               (we),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .hw_int           (hw_int),
    .cp0_wr_exp       (cp0_wr_exp),
    .cp0_clean_exl    (cp0_clean_exl),
    .exp_epc          (exp_epc),
    .exp_in_delayslot (exp_in_delayslot),
    .exp_code         (exp_code),
    .exp_bad_vaddr    (exp_bad_vaddr),
    .cp0_badv_we      (cp0_badv_we),
    .exp_asid         (exp_asid),
    .cp0_exp_asid_we  (cp0_exp_asid_we),
    .allow_int        (allow_int),
    .int_pending      (int_pending),
    .ebase_out        (ebase_out),
    .epc_out          (epc_out),
    .special_int_vec  (special_int_vec),
    .boot_exp_vec     (boot_exp_vec),
    .exl_out          (exl_out),
    .asid_out         (asid_out)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mfc0(input logic [7:0] a, output logic [31:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] v);
    we = 1'b1; wr_addr = a; wr_data = v;
    tick();
    we = 1'b0;
  endtask

  task automatic take_exc(input logic [31:0] epc, input logic ds, input logic [4:0] code,
                          input logic badv_we, input logic [31:0] badv,
                          input logic asid_we, input logic [7:0] asid);
    cp0_wr_exp = 1'b1; exp_epc = epc; exp_in_delayslot = ds; exp_code = code;
    cp0_badv_we = badv_we; exp_bad_vaddr = badv; cp0_exp_asid_we = asid_we; exp_asid = asid;
    tick();
    cp0_wr_exp = 1'b0; cp0_badv_we = 1'b0; cp0_exp_asid_we = 1'b0;
  endtask

  task automatic test_reset();
    mtc0(A_STATUS, 32'h0000_0001);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    vectors++; if (boot_exp_vec !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_bev: got %b expected 1", boot_exp_vec); end
    vectors++; if (allow_int !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_allow_int: got %b expected 0", allow_int); end
    mfc0(A_STATUS, d);
    vectors++; if (d !== 32'h0040_0000) begin miscompares++; $display("[TB] FAIL reset_status: got %h expected 00400000", d); end
    mfc0(A_EBASE, d);
    vectors++; if (d !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL reset_ebase: got %h expected 80000000", d); end
    mfc0(A_COUNT, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_count: got %h expected 0", d); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exception();
    take_exc(32'hBFC0_0104, 1'b1, 5'h02, 1'b1, 32'h0040_1000, 1'b1, 8'h5A);
    mfc0(A_EPC, d);
    vectors++; if (d !== 32'hBFC0_0104) begin miscompares++; $display("[TB] FAIL exc_epc: got %h expected bfc00104", d); end
    mfc0(A_CAUSE, d);
    vectors++; if (d[31] !== 1'b1 || d[6:2] !== 5'h02) begin miscompares++; $display("[TB] FAIL exc_cause: got bd=%b code=%h expected bd=1 code=02", d[31], d[6:2]); end
    mfc0(A_BADV, d);
    vectors++; if (d !== 32'h0040_1000) begin miscompares++; $display("[TB] FAIL exc_badv: got %h expected 00401000", d); end
    vectors++; if (exl_out !== 1'b1 || asid_out !== 8'h5A) begin miscompares++; $display("[TB] FAIL exc_exl_asid: got exl=%b asid=%h expected exl=1 asid=5a", exl_out, asid_out); end
    take_exc(32'h8000_0010, 1'b0, 5'h0C, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'h00);
    mfc0(A_EPC, d);
    vectors++; if (d !== 32'hBFC0_0104 || epc_out !== 32'hBFC0_0104) begin miscompares++; $display("[TB] FAIL nested_epc: got %h/%h expected bfc00104", d, epc_out); end
    mfc0(A_CAUSE, d);
    vectors++; if (d[31] !== 1'b1 || d[6:2] !== 5'h0C) begin miscompares++; $display("[TB] FAIL nested_cause: got bd=%b code=%h expected bd=1 code=0c", d[31], d[6:2]); end
    mfc0(A_BADV, d);
    vectors++; if (d !== 32'h0040_1000) begin miscompares++; $display("[TB] FAIL nested_badv: got %h expected 00401000", d); end
  endtask

  task automatic test_eret_race();
    cp0_clean_exl = 1'b1;
    mtc0(A_STATUS, 32'h0000_FF03);
    cp0_clean_exl = 1'b0;
    mfc0(A_STATUS, d);
    vectors++; if (d !== 32'h0000_FF01) begin miscompares++; $display("[TB] FAIL eret_status: got %h expected 0000ff01", d); end
    vectors++; if (exl_out !== 1'b0 || allow_int !== 1'b1 || boot_exp_vec !== 1'b0) begin miscompares++; $display("[TB] FAIL eret_flags: got exl=%b ie=%b bev=%b expected 0 1 0", exl_out, allow_int, boot_exp_vec); end
  endtask

  task automatic test_exc_race();
    cp0_wr_exp = 1'b1; exp_epc = 32'hBFC0_0200; exp_in_delayslot = 1'b0; exp_code = 5'h00;
    mtc0(A_EPC, 32'h1234_5678);
    cp0_wr_exp = 1'b0;
    mfc0(A_EPC, d);
    vectors++; if (d !== 32'hBFC0_0200) begin miscompares++; $display("[TB] FAIL race_epc: got %h expected bfc00200", d); end
    vectors++; if (exl_out !== 1'b1) begin miscompares++; $display("[TB] FAIL race_exl: got %b expected 1", exl_out); end
    cp0_clean_exl = 1'b1;
    tick();
    cp0_clean_exl = 1'b0;
    vectors++; if (exl_out !== 1'b0) begin miscompares++; $display("[TB] FAIL eret_alone: got %b expected 0", exl_out); end
    we = 1'b1; wr_addr = A_EPC; wr_data = 32'h1234_5678;
    mfc0(A_EPC, d);
    vectors++; if (d !== 32'hBFC0_0200) begin miscompares++; $display("[TB] FAIL no_bypass: got %h expected bfc00200", d); end
    tick();
    we = 1'b0;
    mfc0(A_EPC, d);
    vectors++; if (d !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL mtc0_epc: got %h expected 12345678", d); end
  endtask

  task automatic test_interrupts();
    mtc0(A_STATUS, 32'h0000_0101);
    mtc0(A_CAUSE, 32'h0000_0100);
    vectors++; if (int_pending !== 8'h01) begin miscompares++; $display("[TB] FAIL sw_int: got %h expected 01", int_pending); end
    mtc0(A_CAUSE, 32'h0080_0100);
    vectors++; if (special_int_vec !== 1'b1) begin miscompares++; $display("[TB] FAIL cause_iv: got %b expected 1", special_int_vec); end
    mtc0(A_STATUS, 32'h0000_1101);
    hw_int = 6'b000100;
    #1;
    vectors++; if (int_pending !== 8'h01) begin miscompares++; $display("[TB] FAIL hw_int_early: got %h expected 01", int_pending); end
    tick();
    vectors++; if (int_pending !== 8'h11) begin miscompares++; $display("[TB] FAIL hw_int_latched: got %h expected 11", int_pending); end
    hw_int = 6'b000000;
    tick();
    vectors++; if (int_pending !== 8'h01) begin miscompares++; $display("[TB] FAIL hw_int_drop: got %h expected 01", int_pending); end
  endtask

  task automatic test_misc();
    mfc0(A_PRID, d);
    vectors++; if (d !== 32'h0001_8000) begin miscompares++; $display("[TB] FAIL prid: got %h expected 00018000", d); end
    mtc0(A_EBASE, 32'hFFFF_FFFF);
    mfc0(A_EBASE, d);
    vectors++; if (d !== 32'hBFFF_F000 || ebase_out !== 20'hBFFFF) begin miscompares++; $display("[TB] FAIL ebase_mask: got %h/%h expected bffff000", d, ebase_out); end
    mtc0(A_ENTRYHI, 32'hFFFF_FFFF);
    mfc0(A_ENTRYHI, d);
    vectors++; if (d !== 32'hFFFF_E0FF || asid_out !== 8'hFF) begin miscompares++; $display("[TB] FAIL entryhi_mask: got %h expected ffffe0ff", d); end
    mtc0(A_BADV, 32'hDEAD_BEEF);
    mfc0(A_BADV, d);
    vectors++; if (d !== 32'h0040_1000) begin miscompares++; $display("[TB] FAIL badv_ro: got %h expected 00401000", d); end
    mtc0(8'h7A, 32'hFFFF_FFFF);
    mfc0(8'h7A, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL unmapped: got %h expected 0", d); end
  endtask

  task automatic test_timer();
`ifdef CP0_TIMER_EN
    mtc0(A_STATUS, 32'h0000_8001);
    mtc0(A_COUNT, 32'h0000_0100);
    mtc0(A_COMPARE, 32'd20);
    mtc0(A_COUNT, 32'd10);
    repeat (10) tick();
    mfc0(A_CAUSE, d);
    vectors++; if (d[30] !== 1'b0 || int_pending[7] !== 1'b0) begin miscompares++; $display("[TB] FAIL ti_early: got ti=%b ip7=%b expected 0 0", d[30], int_pending[7]); end
    tick();
    mfc0(A_CAUSE, d);
    vectors++; if (d[30] !== 1'b1 || int_pending[7] !== 1'b1) begin miscompares++; $display("[TB] FAIL ti_set: got ti=%b ip7=%b expected 1 1", d[30], int_pending[7]); end
    mfc0(A_COUNT, d);
    vectors++; if (d !== 32'd21) begin miscompares++; $display("[TB] FAIL count_run: got %h expected 15", d); end
    mtc0(A_COMPARE, 32'h0000_1000);
    mfc0(A_CAUSE, d);
    vectors++; if (d[30] !== 1'b0 || int_pending[7] !== 1'b0) begin miscompares++; $display("[TB] FAIL ti_clear: got ti=%b ip7=%b expected 0 0", d[30], int_pending[7]); end
    mtc0(A_COUNT, 32'hFFFF_FFFF);
    mfc0(A_COUNT, d);
    vectors++; if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL count_load: got %h expected ffffffff", d); end
    tick();
    mfc0(A_COUNT, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL count_wrap: got %h expected 0", d); end
`else
    mtc0(A_COUNT, 32'h0000_0055);
    mtc0(A_COMPARE, 32'h0000_0066);
    mfc0(A_COUNT, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL count_off: got %h expected 0", d); end
    mfc0(A_COMPARE, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL compare_off: got %h expected 0", d); end
    mfc0(A_CAUSE, d);
    vectors++; if (d[30] !== 1'b0) begin miscompares++; $display("[TB] FAIL ti_off: got %b expected 0", d[30]); end
`endif
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0; hw_int = '0;
    cp0_wr_exp = 1'b0; cp0_clean_exl = 1'b0; exp_epc = '0; exp_in_delayslot = 1'b0;
    exp_code = '0; exp_bad_vaddr = '0; cp0_badv_we = 1'b0; exp_asid = '0; cp0_exp_asid_we = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_exception();
    test_eret_race();
    test_exc_race();
    test_interrupts();
    test_misc();
    test_timer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
